// File: rtl/seg_frame_decoder.sv
// Decodes 3-word 7-segment frames (sign, middle '0', ones) into a sign-magnitude value.
// Optional `SEG_FRAME_ERR_COUNT_EN adds a saturating 8-bit err_count output.
module seg_frame_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       seg_valid,
  input  logic       sof,
  output logic [4:0] bits,
  output logic       bits_valid,
`ifdef SEG_FRAME_ERR_COUNT_EN
  output logic [7:0] err_count,
`endif
  output logic       frame_err
);

  typedef enum logic [1:0] {
    WAIT_SIGN = 2'd0,
    WAIT_MID  = 2'd1,
    WAIT_ONES = 2'd2
  } state_t;

  localparam logic [6:0] GLYPH_SIGN_POS = 7'b0000000;
  localparam logic [6:0] GLYPH_SIGN_NEG = 7'b0000001;
  localparam logic [6:0] GLYPH_ZERO     = 7'b1111110;

  state_t     r_state, w_state_nxt;
  logic       r_sign, w_sign_nxt;
  logic [4:0] r_bits, w_bits_nxt;
  logic       r_bits_vld, w_bits_vld;
  logic       r_frame_err, w_frame_err;
  logic [4:0] w_ones;

  // Returns {glyph_ok, magnitude}.
  function automatic logic [4:0] f_decode(input logic [6:0] g);
    case (g)
      7'b1111110: f_decode = {1'b1, 4'h0};
      7'b0110000: f_decode = {1'b1, 4'h1};
      7'b1101101: f_decode = {1'b1, 4'h2};
      7'b1111001: f_decode = {1'b1, 4'h3};
      7'b0110011: f_decode = {1'b1, 4'h4};
      7'b1011011: f_decode = {1'b1, 4'h5};
      7'b1011111: f_decode = {1'b1, 4'h6};
      7'b1110000: f_decode = {1'b1, 4'h7};
      7'b1111111: f_decode = {1'b1, 4'h8};
      7'b1111011: f_decode = {1'b1, 4'h9};
      7'b1110111: f_decode = {1'b1, 4'hA};
      7'b0011111: f_decode = {1'b1, 4'hB};
      7'b1001110: f_decode = {1'b1, 4'hC};
      7'b0111101: f_decode = {1'b1, 4'hD};
      7'b1001111: f_decode = {1'b1, 4'hE};
      7'b1000111: f_decode = {1'b1, 4'hF};
      default:    f_decode = 5'b0_0000;
    endcase
  endfunction

  assign w_ones = f_decode(seg_in);

  always_comb begin
    w_state_nxt = r_state;
    w_sign_nxt  = r_sign;
    w_bits_nxt  = r_bits;
    w_bits_vld  = 1'b0;
    w_frame_err = 1'b0;
    if (seg_valid) begin
      if (sof) begin
        // sof restarts from any state; an abandoned partial frame is silent.
        if (seg_in == GLYPH_SIGN_POS || seg_in == GLYPH_SIGN_NEG) begin
          w_sign_nxt  = seg_in[0];
          w_state_nxt = WAIT_MID;
        end else begin
          w_frame_err = 1'b1;
          w_state_nxt = WAIT_SIGN;
        end
      end else begin
        case (r_state)
          WAIT_MID: begin
            if (seg_in == GLYPH_ZERO) begin
              w_state_nxt = WAIT_ONES;
            end else begin
              w_frame_err = 1'b1;
              w_state_nxt = WAIT_SIGN;
            end
          end
          WAIT_ONES: begin
            w_state_nxt = WAIT_SIGN;
            // Negative zero never leaves a well-behaved encoder.
            if (!w_ones[4] || (r_sign && w_ones[3:0] == 4'h0)) begin
              w_frame_err = 1'b1;
            end else begin
              w_bits_nxt = {r_sign, w_ones[3:0]};
              w_bits_vld = 1'b1;
            end
          end
          default: w_state_nxt = WAIT_SIGN;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= WAIT_SIGN;
      r_sign      <= 1'b0;
      r_bits      <= 5'b00000;
      r_bits_vld  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sign      <= w_sign_nxt;
      r_bits      <= w_bits_nxt;
      r_bits_vld  <= w_bits_vld;
      r_frame_err <= w_frame_err;
    end
  end

  assign bits       = r_bits;
  assign bits_valid = r_bits_vld;
  assign frame_err  = r_frame_err;

`ifdef SEG_FRAME_ERR_COUNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= 8'd0;
    end else if (w_frame_err && r_err_count != 8'hFF) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_seg_frame_decoder.sv
// Directed bench for seg_frame_decoder; err_count checks compile only with SEG_FRAME_ERR_COUNT_EN.
module tb_seg_frame_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_in;
  logic       seg_valid;
  logic       sof;
  logic [4:0] bits;
  logic       bits_valid;
  logic       frame_err;
`ifdef SEG_FRAME_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  seg_frame_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .seg_valid  (seg_valid),
    .sof        (sof),
    .bits       (bits),
    .bits_valid (bits_valid),
`ifdef SEG_FRAME_ERR_COUNT_EN
    .err_count  (err_count),
`endif
    .frame_err  (frame_err)
  );

  // Apply one cycle of inputs, then leave outputs settled 1 time unit after the edge.
  task automatic drive(input logic v, input logic s, input logic [6:0] w);
    seg_valid = v;
    sof       = s;
    seg_in    = w;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b1, 1'b1, 7'b0000001);
    drive(1'b0, 1'b0, 7'b0000000);
    tests_run++;
    if (bits !== 5'b00000) begin tests_failed++; $display("FAIL reset_bits got %b exp %b", bits, 5'b00000); end
    tests_run++;
    if (bits_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_bv got %b exp 0", bits_valid); end
    tests_run++;
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_fe got %b exp 0", frame_err); end
`ifdef SEG_FRAME_ERR_COUNT_EN
    tests_run++;
    if (err_count !== 8'd0) begin tests_failed++; $display("FAIL reset_cnt got %0d exp 0", err_count); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_pos_zero;
    drive(1'b1, 1'b1, 7'b0000000);
    drive(1'b1, 1'b0, 7'b1111110);
    drive(1'b1, 1'b0, 7'b1111110);
    tests_run++;
    if (bits !== 5'b00000 || bits_valid !== 1'b1 || frame_err !== 1'b0) begin
      tests_failed++; $display("FAIL pos_zero got bits=%b bv=%b fe=%b exp 00000 1 0", bits, bits_valid, frame_err);
    end
  endtask

  task automatic test_neg_b;
    drive(1'b1, 1'b1, 7'b0000001);
    tests_run++;
    if (bits_valid !== 1'b0 || frame_err !== 1'b0) begin
      tests_failed++; $display("FAIL neg_b_early got bv=%b fe=%b exp 0 0", bits_valid, frame_err);
    end
    drive(1'b1, 1'b0, 7'b1111110);
    drive(1'b1, 1'b0, 7'b0011111);
    tests_run++;
    if (bits !== 5'b11011 || bits_valid !== 1'b1 || frame_err !== 1'b0) begin
      tests_failed++; $display("FAIL neg_b got bits=%b bv=%b fe=%b exp 11011 1 0", bits, bits_valid, frame_err);
    end
    drive(1'b0, 1'b0, 7'b0000000);
    tests_run++;
    if (bits_valid !== 1'b0 || bits !== 5'b11011) begin
      tests_failed++; $display("FAIL neg_b_pulse got bv=%b bits=%b exp 0 11011", bits_valid, bits);
    end
  endtask

  task automatic test_neg_zero;
    drive(1'b1, 1'b1, 7'b0000001);
    drive(1'b1, 1'b0, 7'b1111110);
    drive(1'b1, 1'b0, 7'b1111110);
    tests_run++;
    if (frame_err !== 1'b1 || bits_valid !== 1'b0 || bits !== 5'b11011) begin
      tests_failed++; $display("FAIL neg_zero got fe=%b bv=%b bits=%b exp 1 0 11011", frame_err, bits_valid, bits);
    end
    drive(1'b0, 1'b0, 7'b0000000);
    tests_run++;
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL neg_zero_pulse got fe=%b exp 0", frame_err); end
  endtask

  task automatic test_bad_words;
    drive(1'b1, 1'b1, 7'b0000010);
    tests_run++;
    if (frame_err !== 1'b1 || bits_valid !== 1'b0) begin
      tests_failed++; $display("FAIL bad_sign got fe=%b bv=%b exp 1 0", frame_err, bits_valid);
    end
    drive(1'b1, 1'b1, 7'b0000000);
    drive(1'b1, 1'b0, 7'b0110000);
    tests_run++;
    if (frame_err !== 1'b1 || bits_valid !== 1'b0) begin
      tests_failed++; $display("FAIL bad_mid got fe=%b bv=%b exp 1 0", frame_err, bits_valid);
    end
    // Stray non-sof words after the error must be ignored silently.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, (i == 0) ? 7'b1111110 : 7'b1111111);
      tests_run++;
      if (frame_err !== 1'b0 || bits_valid !== 1'b0) begin
        tests_failed++; $display("FAIL bad_mid_ignore%0d got fe=%b bv=%b exp 0 0", i, frame_err, bits_valid);
      end
    end
    drive(1'b1, 1'b1, 7'b0000000);
    drive(1'b1, 1'b0, 7'b1111110);
    drive(1'b1, 1'b0, 7'b0000000);
    tests_run++;
    if (frame_err !== 1'b1 || bits_valid !== 1'b0) begin
      tests_failed++; $display("FAIL bad_ones got fe=%b bv=%b exp 1 0", frame_err, bits_valid);
    end
  endtask

  task automatic test_restart_gaps;
    logic any_pulse;
    any_pulse = 1'b0;
    drive(1'b1, 1'b1, 7'b0000001); any_pulse |= bits_valid | frame_err;
    drive(1'b0, 1'b0, 7'b1010101); any_pulse |= bits_valid | frame_err;
    drive(1'b1, 1'b0, 7'b1111110); any_pulse |= bits_valid | frame_err;
    drive(1'b0, 1'b0, 7'b0000000); any_pulse |= bits_valid | frame_err;
    drive(1'b1, 1'b1, 7'b0000000); any_pulse |= bits_valid | frame_err;
    drive(1'b0, 1'b0, 7'b0000000); any_pulse |= bits_valid | frame_err;
    drive(1'b1, 1'b0, 7'b1111110); any_pulse |= bits_valid | frame_err;
    drive(1'b0, 1'b0, 7'b1111111); any_pulse |= bits_valid | frame_err;
    drive(1'b0, 1'b0, 7'b1111111); any_pulse |= bits_valid | frame_err;
    tests_run++;
    if (any_pulse !== 1'b0) begin tests_failed++; $display("FAIL restart_quiet got pulse=%b exp 0", any_pulse); end
    drive(1'b1, 1'b0, 7'b1011011);
    tests_run++;
    if (bits !== 5'b00101 || bits_valid !== 1'b1 || frame_err !== 1'b0) begin
      tests_failed++; $display("FAIL restart got bits=%b bv=%b fe=%b exp 00101 1 0", bits, bits_valid, frame_err);
    end
    drive(1'b0, 1'b0, 7'b0000000);
    tests_run++;
    if (bits_valid !== 1'b0 || frame_err !== 1'b0) begin
      tests_failed++; $display("FAIL restart_single got bv=%b fe=%b exp 0 0", bits_valid, frame_err);
    end
  endtask

  task automatic test_all_digits;
    logic [6:0] glyph [16];
    logic [4:0] exp_bits;
    glyph = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
              7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
              7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    // Back-to-back frames, alternating sign except where magnitude is zero.
    for (int i = 0; i < 16; i++) begin
      exp_bits = {(i != 0) && i[0], i[3:0]};
      drive(1'b1, 1'b1, {6'b000000, exp_bits[4]});
      drive(1'b1, 1'b0, 7'b1111110);
      drive(1'b1, 1'b0, glyph[i]);
      tests_run++;
      if (bits !== exp_bits || bits_valid !== 1'b1 || frame_err !== 1'b0) begin
        tests_failed++; $display("FAIL digit_%0d got bits=%b bv=%b fe=%b exp %b 1 0", i, bits, bits_valid, frame_err, exp_bits);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    drive(1'b1, 1'b1, 7'b0000001);
    drive(1'b1, 1'b0, 7'b1111110);
    rst = 1'b1;
    drive(1'b1, 1'b0, 7'b1111111);
    rst = 1'b0;
    tests_run++;
    if (bits !== 5'b00000 || bits_valid !== 1'b0 || frame_err !== 1'b0) begin
      tests_failed++; $display("FAIL rst_mid got bits=%b bv=%b fe=%b exp 00000 0 0", bits, bits_valid, frame_err);
    end
    drive(1'b1, 1'b0, 7'b1111111);
    tests_run++;
    if (bits !== 5'b00000 || bits_valid !== 1'b0 || frame_err !== 1'b0) begin
      tests_failed++; $display("FAIL rst_mid_after got bits=%b bv=%b fe=%b exp 00000 0 0", bits, bits_valid, frame_err);
    end
    rst = 1'b1;
    drive(1'b1, 1'b1, 7'b0000000);
    rst = 1'b0;
    drive(1'b1, 1'b0, 7'b1111110);
    drive(1'b1, 1'b0, 7'b1111111);
    tests_run++;
    if (bits_valid !== 1'b0 || frame_err !== 1'b0) begin
      tests_failed++; $display("FAIL rst_word_ignored got bv=%b fe=%b exp 0 0", bits_valid, frame_err);
    end
  endtask

`ifdef SEG_FRAME_ERR_COUNT_EN
  task automatic test_err_count;
    rst = 1'b1;
    drive(1'b0, 1'b0, 7'b0000000);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 7'b1111111);
    tests_run++;
    if (err_count !== 8'd5) begin tests_failed++; $display("FAIL err_count_5 got %0d exp 5", err_count); end
    for (int i = 0; i < 295; i++) drive(1'b1, 1'b1, 7'b1111111);
    tests_run++;
    if (err_count !== 8'd255) begin tests_failed++; $display("FAIL err_count_sat got %0d exp 255", err_count); end
  endtask
`endif

  initial begin
    rst       = 1'b0;
    seg_in    = 7'b0000000;
    seg_valid = 1'b0;
    sof       = 1'b0;
    @(negedge clk);
    test_reset;
    test_pos_zero;
    test_neg_b;
    test_neg_zero;
    test_bad_words;
    test_restart_gaps;
    test_all_digits;
    test_reset_mid_frame;
`ifdef SEG_FRAME_ERR_COUNT_EN
    test_err_count;
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seg_frame_decoder.md
SEG_FRAME_DECODER -- requirements
Module: seg_frame_decoder

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port seg_in, input, 7 bits: segment word, order abcdefg = [6:0], active-high.
REQ-004 The block SHALL have the port seg_valid, input, 1 bit: seg_in is valid this cycle; the block has no backpressure and accepts every word.
REQ-005 The block SHALL have the port sof, input, 1 bit: start of frame, qualified by seg_valid, and marks the sign word.
REQ-006 The block SHALL have the port bits, output, 5 bits: decoded value, where [4] is sign and [3:0] is magnitude (sign-magnitude).
REQ-007 The block SHALL have the port bits_valid, output, 1 bit: one-cycle pulse when bits is updated.
REQ-008 The block SHALL have the port frame_err, output, 1 bit: one-cycle pulse when a frame is rejected.

Function
REQ-009 A frame SHALL be exactly three accepted words in order: sign, middle, ones.
REQ-010 Sign word glyphs SHALL be 0000000 (sign 0) and 0000001 (sign 1); any other glyph is an error.
REQ-011 The middle word SHALL be the digit-0 glyph 1111110; any other glyph is an error.
REQ-012 The ones word SHALL decode to the hex glyphs 0-F as follows:
- 0=1111110, 1=0110000, 2=1101101, 3=1111001
- 4=0110011, 5=1011011, 6=1011111, 7=1110000
- 8=1111111, 9=1111011, A=1110111, b=0011111
- C=1001110, d=0111101, E=1001111, F=1000111
- Any other glyph is an error.
REQ-013 Sign 1 with magnitude 0 SHALL be an error, because the encoder blanks the sign when the magnitude is zero.
REQ-014 The FSM SHALL have the states WAIT_SIGN, WAIT_MID and WAIT_ONES.
REQ-015 In any state, seg_valid&sof SHALL restart the frame, evaluating seg_in as a sign word: a good sign goes to WAIT_MID, a bad sign raises an error and goes to WAIT_SIGN.
REQ-016 In WAIT_SIGN, seg_valid without sof SHALL be ignored, with no error.
REQ-017 In WAIT_MID, a good middle word without sof SHALL go to WAIT_ONES, and a bad one SHALL raise an error and go to WAIT_SIGN.
REQ-018 In WAIT_ONES, a word without sof SHALL always return the FSM to WAIT_SIGN, producing either a result or an error.
REQ-019 Cycles with seg_valid=0 SHALL hold all state, and there SHALL be no timeout.
REQ-020 A result SHALL be latency 1: bits is registered and bits_valid=1 on the cycle after the ones word is accepted.
REQ-021 An error SHALL be latency 1: frame_err=1 on the cycle after the offending word, bits is held unchanged, and bits_valid=0.
REQ-022 bits_valid and frame_err SHALL never both be 1 in the same cycle.
REQ-023 A frame abandoned by an sof restart SHALL produce no error pulse.
REQ-024 Back-to-back frames with no idle cycles SHALL be supported.

Reset
REQ-025 While rst=1 at a clk edge, the block SHALL set state=WAIT_SIGN, bits=5'b00000, bits_valid=0 and frame_err=0.
REQ-026 Reset during a frame SHALL discard the partial frame, with no pulse on the following cycle.
REQ-027 A word presented in the same cycle as rst=1 SHALL be ignored.

Configuration
REQ-028 With macro SEG_FRAME_ERR_COUNT_EN defined, the block SHALL add output err_count [7:0], which increments on each frame_err pulse, saturates at 255 and resets to 0.
REQ-029 Without SEG_FRAME_ERR_COUNT_EN, the err_count port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 The bench SHALL cover: frame 0000001(sof), 1111110, 0011111 -> next cycle bits=5'b11011, bits_valid=1 for one cycle.
REQ-031 The bench SHALL cover: frame 0000000(sof), 1111110, 1111110 -> bits=5'b00000, bits_valid pulse, no frame_err.
REQ-032 The bench SHALL cover: frame 0000001(sof), 1111110, 1111110 -> frame_err pulse, bits holds its previous value.
REQ-033 The bench SHALL cover: middle word 0110000 -> frame_err next cycle; the following non-sof words are ignored until an sof arrives.
REQ-034 The bench SHALL cover: sign(sof), then middle, then sof+0000000, 1111110, 1011011 with gaps of seg_valid=0 -> a single bits=5'b00101 pulse and no error.
REQ-035 The bench SHALL cover: rst asserted after the middle word, then the ones word -> no pulse and outputs at reset values; with SEG_FRAME_ERR_COUNT_EN defined, 300 bad frames -> err_count=255.
